// File: rtl/pc_pkg.sv
// Shared constants and the pending-redirect state encoding for the PC generator.
package pc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pend_state_t;

    localparam int          SHAMT_DEF     = 2;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_branch_adder.sv
// Branch target: sign-extended, shifted offset added to the branch's PC+4.
module branch_adder #(
    parameter int WIDTH = 32,
    parameter int OFF_W = 16,
    parameter int SHAMT = 2
) (
    input  logic [WIDTH-1:0] br_pc4,
    input  logic [OFF_W-1:0] br_imm,
    output logic [WIDTH-1:0] target
);

    logic [WIDTH-1:0] imm_ext;

    assign imm_ext = {{(WIDTH-OFF_W){br_imm[OFF_W-1]}}, br_imm};
    assign target  = br_pc4 + (imm_ext << SHAMT);

endmodule

// File: rtl/pc_gen.sv
// Program-counter register with redirect mux and a one-entry latch for
// redirects that arrive while fetch is stalled.
//
// state | meaning
// IDLE  | no redirect held; pc advances or follows a live redirect
// PEND  | a redirect arrived during stall; pend_q holds its target
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               OFF_W     = 16,
    parameter int               J_W       = 26,
    parameter int               SHAMT     = SHAMT_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [WIDTH-1:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_pc4,
    input  logic [OFF_W-1:0] br_imm,
    input  logic             j_en,
    input  logic [J_W-1:0]   j_index,
    input  logic             jr_en,
    input  logic [WIDTH-1:0] jr_addr,
    input  logic             exc_en,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic             pending
);

    localparam logic [WIDTH-1:0] INC = WIDTH'(1) << SHAMT;

    pend_state_t      state;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] sel_target;
    logic             redir;

    branch_adder #(
        .WIDTH (WIDTH),
        .OFF_W (OFF_W),
        .SHAMT (SHAMT)
    ) u_branch_adder (
        .br_pc4 (br_pc4),
        .br_imm (br_imm),
        .target (br_target)
    );

    assign j_target = {br_pc4[WIDTH-1:J_W+SHAMT], j_index, {SHAMT{1'b0}}};
    assign redir    = jr_en | j_en | br_taken;

    always_comb begin
        sel_target = br_target;
        if (jr_en)
            sel_target = jr_addr;
        else if (j_en)
            sel_target = j_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_VEC;
            state  <= IDLE;
            pend_q <= '0;
        end else if (exc_en) begin
            pc     <= EXC_VEC;
            state  <= IDLE;
            pend_q <= '0;
        end else if (stall) begin
            // newest stalled redirect wins; pc is frozen either way
            if (redir) begin
                pend_q <= sel_target;
                state  <= PEND;
            end
        end else if (redir) begin
            pc    <= sel_target;
            state <= IDLE;
        end else if (state == PEND) begin
            pc    <= pend_q;
            state <= IDLE;
        end else begin
            pc <= pc4;
        end
    end

    assign pc4     = pc + INC;
    assign pending = (state == PEND);

endmodule
